i2c_final: RTL and testbench
============================

# i2c_final

Configurable I2C write master with burst support. A host writes the burst length and transfer size into two configuration registers over a simple address/data write port, then strobes `WriteBit`. The block then performs one I2C write transaction to `SlaveAddress`, sending `burst` words taken from `TXIn`, each word `size` bytes long. It sits between the host's register bus and the open-drain SCL/SDA pads.

## Interface
Parameters:
- `SCL_DIV`, default 4: clk cycles per SCL bit period; must be a multiple of 4.
- `CHECK_ACK`, default 0: when 1, a NACK aborts the transaction; when 0, the ACK slot is clocked but not evaluated.

Ports, in positional order:
- `clk`  in  1  single system clock, rising edge.
- `reset`  in  1  asynchronous, active-high; 7th positional port.
- `address`  in  4  configuration register address.
- `data`  in  32  configuration write data.
- `write`  in  1  configuration write enable.
- `WriteBit`  in  1  transaction start request; starts on its rising edge.
- `SlaveAddress`  in  7  7-bit target address.
- `TXIn`  in  32  payload word source.
- `scl`  out  1  I2C clock; 1 = released.
- `sda_oe`  out  1  1 = drive SDA low; 0 = release.
- `sda_in`  in  1  SDA pad value; used only when `CHECK_ACK` = 1.
- `tx_load`  out  1  one-cycle pulse when `TXIn` is captured.
- `busy`, `done`, `nack`  out  1 each  status outputs.

Positional order is clk, address, data, write, WriteBit, SlaveAddress, reset, TXIn, then scl, sda_oe, sda_in, tx_load, busy, done, nack.

## Operation
Configuration registers:
- On a rising edge with `write`=1: address 4 writes `burst` (low 8 bits of `data`); address 8 writes `size` (low 3 bits). Other addresses are ignored.
- Reset values: burst=1, size=4.
- Effective size: values 0 and values above 4 are treated as 4.
- Writes during `busy` are accepted but take effect only at the next transaction.

Start:
- `WriteBit` is registered and rising-edge detected.
- An edge seen while IDLE latches `SlaveAddress`, `burst` and effective `size`, then enters START. Edges seen while busy are ignored.

FSM states: IDLE → START → ADDR (8 bits: SlaveAddress[6:0] MSB first, then R/W=0) → ADDR_ACK → LOAD → DATA (8 bits) → DATA_ACK → (next byte: DATA | next beat: LOAD | last: STOP) → STOP → IDLE.
- If burst=0: ADDR_ACK goes straight to STOP.
- LOAD: one cycle; captures `TXIn` into a 32-bit shift register, pulses `tx_load`, decrements the beats-remaining counter.
- Per beat, bytes are sent from the most significant used byte down: byte index size−1 down to 0, i.e. `TXIn[8*size-1:0]`, each byte MSB first.
- ACK slots: `sda_oe`=0. If `CHECK_ACK`=1 and `sda_in`=1, set `nack` and go to STOP.
- STOP completion pulses `done` for one cycle.
- `busy` = 1 in every state except IDLE.

## Timing
Each bit period is `SCL_DIV` cycles split into four equal quarters:
- quarters 0–1: scl=0; SDA updates at the start of quarter 0.
- quarters 2–3: scl=1.

Conditions:
- START: scl=1, sda_oe goes 0→1 for a half period, then scl low.
- STOP: sda_oe=1 with scl low, then scl high, then sda_oe→0 after a half period.
- Transaction length in bit periods: 1 (START) + 9 (address + ACK) + 9·burst·size + 1 (STOP), plus one LOAD cycle per beat.
- `TXIn` must be stable on the cycle `tx_load` is high.

Reset values: scl=1, sda_oe=0, tx_load=0, busy=0, done=0, nack=0. `nack` clears at the next start.

Reset asserted mid-transaction: immediate return to IDLE with lines released. No STOP condition is generated.

## Structure
- Shared package: FSM state enum, register address constants (4, 8), configuration reset values.
- One natural sub-module: `i2c_bit_timer`, a quarter-phase counter producing scl and quarter strobes from `SCL_DIV`.
- The FSM, configuration registers and shift register stay in the top level.

## Test plan
- Reset and idle: after reset with no start → scl=1, sda_oe=0, busy=0.
- Burst of 2 words, 4 bytes each, `SCL_DIV`=4:
  - Setup: write addr 4 = 2 and addr 8 = 4; `SlaveAddress`=1; raise `WriteBit`; TXIn=7, then 15.
  - Address byte 0x02 (address 1 shifted left, R/W=0).
  - Data bytes 00 00 00 07 then 00 00 00 0F.
  - Exactly 2 `tx_load` pulses; `done` pulses once; total 1+9+72+1 = 83 bit periods plus 2 LOAD cycles.
- size=1, burst=1, TXIn=0xA5C3 → only byte 0xC3 sent.
- burst=0 → START, address, ACK slot, STOP; no `tx_load` pulses.
- `CHECK_ACK`=1 with `sda_in`=1 at the address ACK → `nack`=1, STOP, no data bytes sent.
- Reset asserted mid-DATA → outputs at reset values at once; a new `WriteBit` edge starts a clean transaction.

Source files
------------

// File: rtl/i2c_final_pkg.sv
// Shared types and constants for the I2C burst write master.
package i2c_final_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_ADDR,
    S_ADDR_ACK,
    S_LOAD,
    S_DATA,
    S_DATA_ACK,
    S_STOP
  } state_t;

  localparam logic [3:0] REG_BURST = 4'd4;
  localparam logic [3:0] REG_SIZE  = 4'd8;

  localparam logic [7:0] BURST_RST = 8'd1;
  localparam logic [2:0] SIZE_RST  = 3'd4;

  // Out-of-range byte counts fall back to a full 32-bit word.
  function automatic logic [2:0] eff_size(input logic [2:0] s);
    return ((s == 3'd0) || (s > 3'd4)) ? 3'd4 : s;
  endfunction

endpackage

// File: rtl/i2c_bit_timer.sv
// Quarter-phase counter: SCL_DIV cycles per bit, scl high in quarters 2-3.
// Held at phase 0 while en is low; period_end marks the last cycle of a bit.
module i2c_bit_timer #(
  parameter int SCL_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic scl,
  output logic period_end
);

  localparam int QLEN = SCL_DIV / 4;
  localparam int QW   = (QLEN > 1) ? $clog2(QLEN) : 1;

  logic [QW-1:0] qcnt_q, qcnt_d;
  logic [1:0]    quarter_q, quarter_d;
  logic          q_end;

  always_comb begin
    q_end      = en && (qcnt_q == QW'(QLEN - 1));
    period_end = q_end && (quarter_q == 2'd3);
    qcnt_d     = qcnt_q;
    quarter_d  = quarter_q;
    if (!en) begin
      qcnt_d    = '0;
      quarter_d = 2'd0;
    end else if (q_end) begin
      qcnt_d    = '0;
      quarter_d = quarter_q + 2'd1;
    end else begin
      qcnt_d = qcnt_q + QW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      qcnt_q    <= '0;
      quarter_q <= 2'd0;
    end else begin
      qcnt_q    <= qcnt_d;
      quarter_q <= quarter_d;
    end
  end

  assign scl = quarter_q[1];

endmodule

// File: rtl/i2c_final.sv
// I2C burst write master: one START/address/data.../STOP transaction per WriteBit rising edge.
// Line outputs are registered (one cycle behind the FSM); TXIn is captured on the tx_load cycle.
module i2c_final
  import i2c_final_pkg::*;
#(
  parameter int SCL_DIV   = 4,
  parameter bit CHECK_ACK = 1'b0
) (
  input  logic        clk,
  input  logic [3:0]  address,
  input  logic [31:0] data,
  input  logic        write,
  input  logic        WriteBit,
  input  logic [6:0]  SlaveAddress,
  input  logic        reset,
  input  logic [31:0] TXIn,
  output logic        scl,
  output logic        sda_oe,
  input  logic        sda_in,
  output logic        tx_load,
  output logic        busy,
  output logic        done,
  output logic        nack
);

  state_t      state_q, state_d;
  logic [7:0]  burst_cfg_q, burst_cfg_d;
  logic [2:0]  size_cfg_q, size_cfg_d;
  logic        wb_q, wb_prev_q;
  logic [31:0] sh_q, sh_d;
  logic [7:0]  beats_q, beats_d;
  logic [2:0]  size_q, size_d;
  logic [2:0]  bit_q, bit_d;
  logic [1:0]  byte_q, byte_d;
  logic        scl_q, scl_d, sda_oe_q, sda_oe_d;
  logic        tx_load_q, tx_load_d, busy_q, busy_d;
  logic        done_q, done_d, nack_q, nack_d;
  logic        tmr_en, tmr_scl, period_end, start_edge, ack_fail;
  logic        unused_data;

  assign unused_data = ^data[31:8];
  assign tmr_en      = (state_q != S_IDLE) && (state_q != S_LOAD);
  assign start_edge  = wb_q && !wb_prev_q;
  assign ack_fail    = CHECK_ACK && sda_in;

  i2c_bit_timer #(.SCL_DIV(SCL_DIV)) u_timer (
    .clk        (clk),
    .rst        (reset),
    .en         (tmr_en),
    .scl        (tmr_scl),
    .period_end (period_end)
  );

  always_comb begin
    state_d     = state_q;
    burst_cfg_d = burst_cfg_q;
    size_cfg_d  = size_cfg_q;
    sh_d        = sh_q;
    beats_d     = beats_q;
    size_d      = size_q;
    bit_d       = bit_q;
    byte_d      = byte_q;
    nack_d      = nack_q;
    scl_d       = scl_q;
    sda_oe_d    = sda_oe_q;

    if (write && (address == REG_BURST)) burst_cfg_d = data[7:0];
    if (write && (address == REG_SIZE))  size_cfg_d  = data[2:0];

    case (state_q)
      S_IDLE: if (start_edge) begin
        state_d = S_START;
        sh_d    = {SlaveAddress, 1'b0, 24'h0};
        beats_d = burst_cfg_q;
        size_d  = eff_size(size_cfg_q);
        nack_d  = 1'b0;
      end
      S_START: if (period_end) begin
        state_d = S_ADDR;
        bit_d   = 3'd7;
      end
      S_ADDR, S_DATA: if (period_end) begin
        sh_d  = {sh_q[30:0], 1'b0};
        bit_d = bit_q - 3'd1;
        if (bit_q == 3'd0) state_d = (state_q == S_ADDR) ? S_ADDR_ACK : S_DATA_ACK;
      end
      S_ADDR_ACK: if (period_end) begin
        if (ack_fail) begin
          nack_d  = 1'b1;
          state_d = S_STOP;
        end else begin
          state_d = (beats_q == 8'd0) ? S_STOP : S_LOAD;
        end
      end
      S_LOAD: begin
        // Left-justify the used bytes so the MSB of the first byte is always sh_q[31].
        case (size_q)
          3'd1:    sh_d = {TXIn[7:0], 24'h0};
          3'd2:    sh_d = {TXIn[15:0], 16'h0};
          3'd3:    sh_d = {TXIn[23:0], 8'h0};
          default: sh_d = TXIn;
        endcase
        beats_d = beats_q - 8'd1;
        byte_d  = 2'(size_q - 3'd1);
        bit_d   = 3'd7;
        state_d = S_DATA;
      end
      S_DATA_ACK: if (period_end) begin
        if (ack_fail) begin
          nack_d  = 1'b1;
          state_d = S_STOP;
        end else if (byte_q != 2'd0) begin
          byte_d  = byte_q - 2'd1;
          bit_d   = 3'd7;
          state_d = S_DATA;
        end else begin
          state_d = (beats_q != 8'd0) ? S_LOAD : S_STOP;
        end
      end
      S_STOP: if (period_end) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    case (state_q)
      S_IDLE:                begin scl_d = 1'b1;    sda_oe_d = 1'b0;     end
      S_START:               begin scl_d = 1'b1;    sda_oe_d = tmr_scl;  end
      S_ADDR, S_DATA:        begin scl_d = tmr_scl; sda_oe_d = !sh_q[31]; end
      S_ADDR_ACK, S_DATA_ACK: begin scl_d = tmr_scl; sda_oe_d = 1'b0;     end
      S_STOP:                begin scl_d = tmr_scl; sda_oe_d = 1'b1;     end
      default:               ;
    endcase

    busy_d    = (state_d != S_IDLE);
    tx_load_d = (state_d == S_LOAD);
    done_d    = (state_q == S_STOP) && (state_d == S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      burst_cfg_q <= BURST_RST;
      size_cfg_q  <= SIZE_RST;
      wb_q        <= 1'b0;
      wb_prev_q   <= 1'b0;
      sh_q        <= '0;
      beats_q     <= '0;
      size_q      <= SIZE_RST;
      bit_q       <= '0;
      byte_q      <= '0;
      scl_q       <= 1'b1;
      sda_oe_q    <= 1'b0;
      tx_load_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      nack_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_cfg_q <= burst_cfg_d;
      size_cfg_q  <= size_cfg_d;
      wb_q        <= WriteBit;
      wb_prev_q   <= wb_q;
      sh_q        <= sh_d;
      beats_q     <= beats_d;
      size_q      <= size_d;
      bit_q       <= bit_d;
      byte_q      <= byte_d;
      scl_q       <= scl_d;
      sda_oe_q    <= sda_oe_d;
      tx_load_q   <= tx_load_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      nack_q      <= nack_d;
    end
  end

  assign scl     = scl_q;
  assign sda_oe  = sda_oe_q;
  assign tx_load = tx_load_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign nack    = nack_q;

endmodule

// File: tb/tb_i2c_final.sv
// Bench for i2c_final: decodes the SCL/SDA lines back into bytes and compares them with a byte-level transaction model.
module tb_i2c_final;

  localparam int SCL_DIV = 4;

  logic        clk = 1'b0;
  logic [3:0]  address = '0;
  logic [31:0] data = '0;
  logic        write = 1'b0;
  logic        WriteBit = 1'b0;
  logic [6:0]  SlaveAddress = '0;
  logic        reset = 1'b1;
  logic [31:0] TXIn = '0;
  logic        scl, sda_oe, tx_load, busy, done, nack;
  logic        sda_in = 1'b0;

  i2c_final #(.SCL_DIV(SCL_DIV), .CHECK_ACK(1'b1)) dut (
    .clk(clk), .address(address), .data(data), .write(write), .WriteBit(WriteBit),
    .SlaveAddress(SlaveAddress), .reset(reset), .TXIn(TXIn), .scl(scl), .sda_oe(sda_oe),
    .sda_in(sda_in), .tx_load(tx_load), .busy(busy), .done(done), .nack(nack)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  exp_bytes[$];
  int          exp_loads, exp_busy;
  logic        exp_nack;
  logic [31:0] tx_words[$];

  logic [7:0] rx_bytes[$];
  int         busy_cycles, load_cnt, done_cnt, start_cnt, stop_cnt, ack_rel, nbits;
  logic       frame_ok, seen_load;
  logic [8:0] bitbuf;
  logic       scl_p = 1'b1, oe_p = 1'b0, busy_p = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Expected bytes and timing straight from the transaction rules.
  task automatic model_build(input logic [6:0] sa, input int burst, input int size_raw, input bit nak);
    int sz;
    logic [31:0] w;
    sz = ((size_raw == 0) || (size_raw > 4)) ? 4 : size_raw;
    exp_bytes.delete();
    exp_bytes.push_back({sa, 1'b0});
    exp_nack = nak;
    if (nak) begin
      exp_loads = 0;
      exp_busy  = SCL_DIV * 11;
    end else begin
      for (int k = 0; k < burst; k++) begin
        w = tx_words[k];
        for (int b = sz - 1; b >= 0; b--) exp_bytes.push_back(w[8*b +: 8]);
      end
      exp_loads = burst;
      exp_busy  = SCL_DIV * (11 + 9 * burst * sz) + burst;
    end
  endtask

  task automatic mon_clear();
    rx_bytes.delete();
    busy_cycles = 0; load_cnt = 0; done_cnt = 0; start_cnt = 0; stop_cnt = 0;
    ack_rel = 0; nbits = 0; frame_ok = 1'b0; seen_load = 1'b0; bitbuf = '0;
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    address = a; data = d; write = 1'b1;
    @(posedge clk); #1;
    write = 1'b0;
  endtask

  task automatic start_txn(input logic [6:0] sa);
    SlaveAddress = sa;
    TXIn = (tx_words.size() > 0) ? tx_words[0] : 32'h0;
    @(posedge clk); #1;
    mon_clear();
    WriteBit = 1'b1;
    repeat (3) @(posedge clk);
    #1 WriteBit = 1'b0;
  endtask

  task automatic wait_loads(input string nm, input int n);
    int i;
    for (i = 0; i < 2000; i++) begin
      @(posedge clk);
      if (load_cnt >= n) break;
    end
    chk({nm, "_load_timeout"}, 32'(load_cnt >= n), 32'd1);
  endtask

  task automatic check_txn(input string nm);
    int i;
    for (i = 0; i < 3000; i++) begin
      @(posedge clk);
      if (done_cnt != 0) break;
    end
    chk({nm, "_done_timeout"}, 32'(done_cnt != 0), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    chk({nm, "_nbytes"}, rx_bytes.size(), exp_bytes.size());
    for (int j = 0; j < exp_bytes.size(); j++)
      chk($sformatf("%s_byte%0d", nm, j), (j < rx_bytes.size()) ? {24'h0, rx_bytes[j]} : 32'hBAD, {24'h0, exp_bytes[j]});
    chk({nm, "_starts"}, start_cnt, 1);
    chk({nm, "_stops"}, stop_cnt, 1);
    chk({nm, "_stop_frame"}, 32'(frame_ok), 32'd1);
    chk({nm, "_acks_released"}, ack_rel, exp_bytes.size());
    chk({nm, "_tx_loads"}, load_cnt, exp_loads);
    chk({nm, "_done_pulses"}, done_cnt, 1);
    chk({nm, "_busy_cycles"}, busy_cycles, exp_busy);
    chk({nm, "_nack"}, 32'(nack), 32'(exp_nack));
  endtask

  initial begin
    mon_clear();
    fork
      forever begin
        @(negedge clk);
        if (!busy && !busy_p) chk("idle_lines", {29'h0, scl, sda_oe, tx_load}, 32'b100);
        if (busy) busy_cycles++;
        if (done) done_cnt++;
        if (seen_load && (load_cnt < tx_words.size())) TXIn = tx_words[load_cnt];
        seen_load = tx_load;
        if (tx_load) load_cnt++;
        if (scl && scl_p && sda_oe && !oe_p) begin
          start_cnt++;
          nbits = 0;
        end else if (scl && scl_p && !sda_oe && oe_p) begin
          stop_cnt++;
          frame_ok = (nbits == 1) && (bitbuf[0] == 1'b0);
        end else if (scl && !scl_p) begin
          bitbuf = {bitbuf[7:0], ~sda_oe};
          nbits++;
          if (nbits == 9) begin
            rx_bytes.push_back(bitbuf[8:1]);
            if (bitbuf[0]) ack_rel++;
            nbits = 0;
          end
        end
        scl_p = scl; oe_p = sda_oe; busy_p = busy;
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_scl", 32'(scl), 32'd1);
        chk("rst_sda_oe", 32'(sda_oe), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_status", {29'h0, tx_load, done, nack}, 32'd0);
        reset = 1'b0;
        repeat (10) @(posedge clk);

        // Burst of two full words; a burst write mid-flight must not alter it.
        cfg_write(4'd4, 32'd2);
        cfg_write(4'd8, 32'd4);
        tx_words = '{32'h7, 32'hF};
        model_build(7'h01, 2, 4, 1'b0);
        start_txn(7'h01);
        wait_loads("burst2", 1);
        cfg_write(4'd4, 32'd1);
        check_txn("burst2");
        chk("burst2_addr_lit", {24'h0, rx_bytes[0]}, 32'h02);
        chk("burst2_w0_lit", {24'h0, rx_bytes[4]}, 32'h07);
        chk("burst2_w1_lit", {24'h0, rx_bytes[8]}, 32'h0F);
        chk("burst2_busy_lit", busy_cycles, 334);

        // Single byte per word.
        cfg_write(4'd8, 32'd1);
        tx_words = '{32'hA5C3};
        model_build(7'h55, 1, 1, 1'b0);
        start_txn(7'h55);
        check_txn("size1");
        chk("size1_byte_lit", {24'h0, rx_bytes[1]}, 32'hC3);
        chk("size1_count_lit", rx_bytes.size(), 2);

        // Zero-length burst: address only.
        cfg_write(4'd4, 32'd0);
        tx_words = {};
        model_build(7'h2A, 0, 1, 1'b0);
        start_txn(7'h2A);
        check_txn("burst0");
        chk("burst0_loads_lit", load_cnt, 0);

        // Address NACK aborts before any data.
        cfg_write(4'd4, 32'd1);
        tx_words = '{32'h99};
        sda_in = 1'b1;
        model_build(7'h3C, 1, 1, 1'b1);
        start_txn(7'h3C);
        check_txn("nack");
        chk("nack_lit", 32'(nack), 32'd1);
        sda_in = 1'b0;

        // Size 0 means 4 bytes; address 12 is not a register.
        cfg_write(4'd8, 32'd0);
        cfg_write(4'd12, 32'd5);
        tx_words = '{32'h11223344};
        model_build(7'h10, 1, 0, 1'b0);
        start_txn(7'h10);
        check_txn("size0");
        chk("size0_first_lit", {24'h0, rx_bytes[1]}, 32'h11);

        // Reset in the middle of data, then a clean restart on reset configuration.
        tx_words = '{32'h12345678};
        start_txn(7'h30);
        wait_loads("abort", 1);
        repeat (10) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("abort_scl", 32'(scl), 32'd1);
        chk("abort_sda_oe", 32'(sda_oe), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_status", {29'h0, tx_load, done, nack}, 32'd0);
        chk("abort_no_done", done_cnt, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (4) @(posedge clk);
        tx_words = '{32'hDEADBEEF};
        model_build(7'h30, 1, 4, 1'b0);
        start_txn(7'h30);
        check_txn("restart");
        chk("restart_busy_lit", busy_cycles, 189);
        chk("restart_last_lit", {24'h0, rx_bytes[4]}, 32'hEF);
      end
    join_any
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
